// File: rtl/rob_commit_queue.sv
// rob_commit_queue: in-order reorder buffer.
// Allocates one uid per dispatched instruction at the tail, takes completion results
// in any order, and retires from the head strictly in program order. Retirement drives
// a registered register-file write stream. The writer-tag update for the register file
// is a combinational strobe issued in the allocation cycle.

`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 3
`endif

module rob_commit_queue #(
   parameter int ROB_QUEUE_BITS = `ROB_QUEUE_BITS,
   parameter int ROB_QUEUE_SIZE = 1 << ROB_QUEUE_BITS
) (
   input  logic                      clk,
   input  logic                      reset,
   // dispatch side
   input  logic                      alloc_valid,
   input  logic                      alloc_has_dest,
   input  logic [3:0]                alloc_waddr,
   output logic                      alloc_ready,
   output logic [ROB_QUEUE_BITS-1:0] alloc_uid,
   // writer-tag update towards the register file
   output logic                      change_writer,
   output logic [3:0]                writer_waddr,
   output logic [ROB_QUEUE_BITS-1:0] new_writer,
   // completion side
   input  logic                      cmp_valid,
   input  logic [ROB_QUEUE_BITS-1:0] cmp_uid,
   input  logic [15:0]               cmp_data,
   // retirement stream
   output logic                      commit_valid,
   output logic [3:0]                commit_waddr,
   output logic [15:0]               commit_data,
   output logic [ROB_QUEUE_BITS-1:0] commit_uid,
   // control / status
   input  logic                      flush_all,
   output logic [ROB_QUEUE_BITS:0]   count
);

   localparam int CW = ROB_QUEUE_BITS + 1;

   // Advance a ring pointer, wrapping the last slot back to 0.
   function automatic logic [ROB_QUEUE_BITS-1:0] ptr_inc(input logic [ROB_QUEUE_BITS-1:0] p);
      if (p == ROB_QUEUE_BITS'(ROB_QUEUE_SIZE - 1)) begin
         return '0;
      end
      return p + ROB_QUEUE_BITS'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // Pointer / occupancy state
   // ---------------------------------------------------------------------------
   logic [ROB_QUEUE_BITS-1:0] head_reg, head_next;
   logic [ROB_QUEUE_BITS-1:0] tail_reg, tail_next;
   logic [CW-1:0]             count_reg, count_next;

   // Per-entry state, gathered from the generate blocks below.
   logic [ROB_QUEUE_SIZE-1:0] valid_vec;
   logic [ROB_QUEUE_SIZE-1:0] done_vec;
   logic [ROB_QUEUE_SIZE-1:0] has_dest_vec;
   logic [3:0]                waddr_vec [ROB_QUEUE_SIZE];
   logic [15:0]               data_vec  [ROB_QUEUE_SIZE];

   // Control strobes for this cycle.
   logic                      alloc_fire;
   logic                      retire;
   logic                      head_has_dest;
   logic [3:0]                head_waddr;
   logic [15:0]               head_data;

   // Refuse allocation while in reset, and whenever the current occupancy is full.
   // A retire in the same cycle does not free a slot early.
   assign alloc_ready = !reset && (count_reg < CW'(ROB_QUEUE_SIZE));
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign alloc_uid   = tail_reg;

   // Register 0 is hard-wired, so it never gets a writer tag.
   assign change_writer = alloc_fire && alloc_has_dest && (alloc_waddr != 4'd0);
   assign writer_waddr  = alloc_waddr;
   assign new_writer    = tail_reg;

   // The head retires once it has been marked done at an earlier edge.
   // Completion writes land in done_vec at the edge, so a completion never
   // bypasses into a same-edge retire.
   assign retire        = valid_vec[head_reg] && done_vec[head_reg];
   assign head_has_dest = has_dest_vec[head_reg];
   assign head_waddr    = waddr_vec[head_reg];
   assign head_data     = data_vec[head_reg];

   assign count = count_reg;

   // ---------------------------------------------------------------------------
   // Per-entry storage
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < ROB_QUEUE_SIZE; gi++) begin : g_entry
         logic        valid_reg;
         logic        done_reg;
         logic        has_dest_reg;
         logic [3:0]  waddr_reg;
         logic [15:0] data_reg;
         logic        alloc_here;
         logic        retire_here;
         logic        cmp_here;

         assign alloc_here  = alloc_fire && (tail_reg == ROB_QUEUE_BITS'(gi));
         assign retire_here = retire && (head_reg == ROB_QUEUE_BITS'(gi));
         // Completion only counts for an occupied slot; a slot being allocated in
         // this same cycle is still empty, so its completion is dropped.
         assign cmp_here    = cmp_valid && (cmp_uid == ROB_QUEUE_BITS'(gi)) && valid_reg;

         // Entry status: flush/reset clear, allocation opens, retire closes, completion marks done.
         always_ff @(posedge clk) begin
            if (reset || flush_all) begin
               valid_reg <= 1'b0;
               done_reg  <= 1'b0;
            end else if (alloc_here) begin
               valid_reg <= 1'b1;
               done_reg  <= 1'b0;
            end else if (retire_here) begin
               valid_reg <= 1'b0;
               done_reg  <= 1'b0;
            end else if (cmp_here) begin
               done_reg  <= 1'b1;
            end
         end

         // Entry payload: destination captured on allocation, result on (every) completion.
         always_ff @(posedge clk) begin
            if (alloc_here) begin
               has_dest_reg <= alloc_has_dest;
               waddr_reg    <= alloc_waddr;
            end
            if (cmp_here) begin
               data_reg     <= cmp_data;
            end
         end

         assign valid_vec[gi]    = valid_reg;
         assign done_vec[gi]     = done_reg;
         assign has_dest_vec[gi] = has_dest_reg;
         assign waddr_vec[gi]    = waddr_reg;
         assign data_vec[gi]     = data_reg;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Pointers and occupancy
   // ---------------------------------------------------------------------------

   // Next-state for head, tail and count from this cycle's alloc/retire strobes.
   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (alloc_fire) begin
         tail_next = ptr_inc(tail_reg);
      end
      if (retire) begin
         head_next = ptr_inc(head_reg);
      end
      if (alloc_fire && !retire) begin
         count_next = count_reg + CW'(1);
      end else if (!alloc_fire && retire) begin
         count_next = count_reg - CW'(1);
      end
   end

   // Pointer/count registers; flush empties the queue the same way reset does.
   always_ff @(posedge clk) begin
      if (reset || flush_all) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Retirement stream
   // ---------------------------------------------------------------------------

   // Commit registers: load the retiring head; pulse valid only for a real register write.
   always_ff @(posedge clk) begin
      if (reset) begin
         commit_valid <= 1'b0;
         commit_waddr <= 4'd0;
         commit_data  <= 16'd0;
         commit_uid   <= '0;
      end else if (flush_all) begin
         commit_valid <= 1'b0;
      end else if (retire) begin
         commit_valid <= head_has_dest && (head_waddr != 4'd0);
         commit_waddr <= head_waddr;
         commit_data  <= head_data;
         commit_uid   <= head_reg;
      end else begin
         commit_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rob_commit_queue.sv
// tb_rob_commit_queue: directed bench for the reorder buffer.
// Allocations push the expected retirement order into a scoreboard queue and
// completions fill a data model. Every commit pulse pops the queue and is
// checked against it.

module tb_rob_commit_queue;

   localparam int B = 3;
   localparam int N = 1 << B;

   logic          clk = 1'b0;
   logic          reset;
   logic          alloc_valid;
   logic          alloc_has_dest;
   logic [3:0]    alloc_waddr;
   logic          alloc_ready;
   logic [B-1:0]  alloc_uid;
   logic          change_writer;
   logic [3:0]    writer_waddr;
   logic [B-1:0]  new_writer;
   logic          cmp_valid;
   logic [B-1:0]  cmp_uid;
   logic [15:0]   cmp_data;
   logic          commit_valid;
   logic [3:0]    commit_waddr;
   logic [15:0]   commit_data;
   logic [B-1:0]  commit_uid;
   logic          flush_all;
   logic [B:0]    count;

   typedef struct {
      logic [B-1:0] uid;
      logic [3:0]   waddr;
      logic         loud;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] model_data [N];
   int          checks = 0;
   int          errors = 0;
   int          commits_seen = 0;
   int          c0;

   always #5 clk = ~clk;

   rob_commit_queue #(.ROB_QUEUE_BITS(B), .ROB_QUEUE_SIZE(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .alloc_valid    (alloc_valid),
      .alloc_has_dest (alloc_has_dest),
      .alloc_waddr    (alloc_waddr),
      .alloc_ready    (alloc_ready),
      .alloc_uid      (alloc_uid),
      .change_writer  (change_writer),
      .writer_waddr   (writer_waddr),
      .new_writer     (new_writer),
      .cmp_valid      (cmp_valid),
      .cmp_uid        (cmp_uid),
      .cmp_data       (cmp_data),
      .commit_valid   (commit_valid),
      .commit_waddr   (commit_waddr),
      .commit_data    (commit_data),
      .commit_uid     (commit_uid),
      .flush_all      (flush_all),
      .count          (count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then check any commit pulse against the scoreboard.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (commit_valid === 1'b1) begin
         while (sb.size() > 0 && !sb[0].loud) void'(sb.pop_front());
         chk("commit_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("commit_uid", commit_uid, e.uid);
            chk("commit_waddr", commit_waddr, e.waddr);
            chk("commit_data", commit_data, model_data[e.uid]);
         end
         commits_seen++;
         $display("commit uid=%0d waddr=%0d data=%h", commit_uid, commit_waddr, commit_data);
      end
   endtask

   task automatic drain_silent();
      while (sb.size() > 0 && !sb[0].loud) void'(sb.pop_front());
   endtask

   task automatic do_alloc(input logic [3:0] wa, input logic hd, input logic [B-1:0] exp_uid);
      exp_t e;
      logic loud;
      loud = hd && (wa != 4'd0);
      alloc_valid = 1'b1;
      alloc_waddr = wa;
      alloc_has_dest = hd;
      #1;
      chk("alloc_ready", alloc_ready, 1'b1);
      chk("alloc_uid", alloc_uid, exp_uid);
      chk("change_writer", change_writer, loud);
      if (loud) begin
         chk("writer_waddr", writer_waddr, wa);
         chk("new_writer", new_writer, exp_uid);
      end
      e.uid = exp_uid;
      e.waddr = wa;
      e.loud = loud;
      sb.push_back(e);
      $display("alloc uid=%0d waddr=%0d has_dest=%0d", exp_uid, wa, hd);
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_cmp(input logic [B-1:0] u, input logic [15:0] d, input logic upd);
      cmp_valid = 1'b1;
      cmp_uid = u;
      cmp_data = d;
      if (upd) model_data[u] = d;
      $display("complete uid=%0d data=%h", u, d);
      tick();
      cmp_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      alloc_valid = 1'b0;
      alloc_has_dest = 1'b0;
      alloc_waddr = 4'd0;
      cmp_valid = 1'b0;
      cmp_uid = '0;
      cmp_data = 16'd0;
      flush_all = 1'b0;
      for (int i = 0; i < N; i++) model_data[i] = 16'd0;

      // ---- reset ----
      tick();
      tick();
      chk("reset_alloc_ready", alloc_ready, 1'b0);
      chk("reset_count", count, 0);
      chk("reset_commit_valid", commit_valid, 1'b0);
      chk("reset_commit_uid", commit_uid, 0);
      chk("reset_commit_data", commit_data, 0);
      chk("reset_commit_waddr", commit_waddr, 0);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", alloc_ready, 1'b1);
      chk("uid_after_reset", alloc_uid, 0);

      // ---- three allocations ----
      do_alloc(4'd1, 1'b1, 3'd0);
      do_alloc(4'd2, 1'b1, 3'd1);
      do_alloc(4'd3, 1'b1, 3'd2);
      chk("count_three", count, 3);

      // ---- out-of-order completion, in-order commit ----
      c0 = commits_seen;
      do_cmp(3'd2, 16'h0099, 1'b1);
      do_cmp(3'd2, 16'h0022, 1'b1);   // duplicate overwrites
      do_cmp(3'd0, 16'h00AA, 1'b1);
      chk("no_same_edge_bypass", commits_seen - c0, 0);
      do_cmp(3'd1, 16'h0011, 1'b1);
      chk("first_commit_timing", commits_seen - c0, 1);
      tick();
      chk("second_commit_timing", commits_seen - c0, 2);
      tick();
      chk("third_commit_timing", commits_seen - c0, 3);
      tick();
      chk("no_extra_commit", commits_seen - c0, 3);
      chk("count_drained", count, 0);

      // ---- fill to full, refused alloc, wrap ----
      flush_all = 1'b1;
      tick();
      flush_all = 1'b0;
      chk("flush_empty_count", count, 0);
      chk("flush_empty_uid", alloc_uid, 0);
      for (int i = 0; i < N; i++) do_alloc(4'(i + 1), 1'b1, B'(i));
      chk("count_full", count, N);
      alloc_valid = 1'b1;
      alloc_waddr = 4'hF;
      alloc_has_dest = 1'b1;
      #1;
      chk("full_not_ready", alloc_ready, 1'b0);
      chk("full_no_change_writer", change_writer, 1'b0);
      tick();
      chk("full_alloc_ignored", count, N);
      chk("full_tail_wrapped", alloc_uid, 0);
      c0 = commits_seen;
      cmp_valid = 1'b1;
      cmp_uid = 3'd0;
      cmp_data = 16'h1234;
      model_data[0] = 16'h1234;
      tick();
      cmp_valid = 1'b0;
      chk("full_after_cmp", count, N);
      #1;
      chk("full_retire_cycle_not_ready", alloc_ready, 1'b0);
      tick();
      alloc_valid = 1'b0;
      chk("retire_frees_one", count, N - 1);
      chk("retire_commit_seen", commits_seen - c0, 1);
      #1;
      chk("ready_after_retire", alloc_ready, 1'b1);
      chk("wrap_uid", alloc_uid, 0);
      for (int i = 1; i < N; i++) do_cmp(B'(i), 16'h0100 + 16'(i), 1'b1);
      tick();
      tick();
      chk("full_drain_count", count, 0);
      chk("full_drain_commits", commits_seen - c0, N);
      chk("full_drain_sb", sb.size(), 0);

      // ---- register 0 and no-dest entries ----
      c0 = commits_seen;
      do_alloc(4'd0, 1'b1, 3'd0);
      do_alloc(4'd5, 1'b0, 3'd1);
      do_cmp(3'd0, 16'hA0A0, 1'b1);
      do_cmp(3'd1, 16'hB1B1, 1'b1);
      tick();
      tick();
      chk("silent_no_commit", commits_seen - c0, 0);
      chk("silent_count", count, 0);
      chk("silent_commit_uid", commit_uid, 1);
      chk("silent_commit_data", commit_data, 16'hB1B1);
      drain_silent();
      chk("silent_sb", sb.size(), 0);

      // ---- flush with same-cycle alloc and completion ----
      do_alloc(4'd1, 1'b1, 3'd2);
      do_alloc(4'd2, 1'b1, 3'd3);
      do_alloc(4'd3, 1'b1, 3'd4);
      do_alloc(4'd4, 1'b1, 3'd5);
      do_cmp(3'd3, 16'h3333, 1'b1);
      do_cmp(3'd4, 16'h4444, 1'b1);
      chk("preflush_count", count, 4);
      c0 = commits_seen;
      flush_all = 1'b1;
      alloc_valid = 1'b1;
      alloc_waddr = 4'd6;
      alloc_has_dest = 1'b1;
      cmp_valid = 1'b1;
      cmp_uid = 3'd2;
      cmp_data = 16'h2222;
      $display("flush with alloc and complete");
      tick();
      flush_all = 1'b0;
      alloc_valid = 1'b0;
      cmp_valid = 1'b0;
      sb.delete();
      chk("flush_count", count, 0);
      chk("flush_uid", alloc_uid, 0);
      chk("flush_commit_valid", commit_valid, 1'b0);
      tick();
      tick();
      tick();
      chk("flush_no_commit", commits_seen - c0, 0);
      chk("flush_count_stays", count, 0);

      // ---- completion to empty slot, then same-cycle alloc+complete ----
      do_cmp(3'd5, 16'h5A5A, 1'b0);
      chk("empty_cmp_count", count, 0);
      chk("empty_cmp_uid", alloc_uid, 0);
      for (int i = 0; i < 5; i++) do_alloc(4'(i + 1), 1'b1, B'(i));
      cmp_valid = 1'b1;
      cmp_uid = 3'd5;
      cmp_data = 16'hDEAD;
      do_alloc(4'd6, 1'b1, 3'd5);
      cmp_valid = 1'b0;
      c0 = commits_seen;
      for (int i = 0; i < 5; i++) do_cmp(B'(i), 16'h0600 + 16'(i), 1'b1);
      tick();
      tick();
      tick();
      chk("slot5_waits_count", count, 1);
      chk("slot5_waits_commits", commits_seen - c0, 5);
      do_cmp(3'd5, 16'h5555, 1'b1);
      tick();
      tick();
      chk("slot5_commit", commits_seen - c0, 6);
      chk("final_count", count, 0);
      chk("final_sb", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
